gbe_tx_packetizer: RTL and testbench

Streaming packetizer sitting directly upstream of the 10GbE core's fabric transmit port. It accepts an unstallable stream of 64-bit spectral words, buffers them in an internal show-ahead FIFO, and emits UDP payload frames. Each frame is one 64-bit header word followed by PAYLOAD_WORDS data words. Frames are emitted on the core's tx_valid/tx_data/tx_end_of_frame/tx_dest_ip/tx_dest_port interface, with tx_afull respected.

---
 rtl/gbe_tx_packetizer.sv | 159 +++++++++++++++
 tb/tb_gbe_tx_packetizer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/gbe_tx_packetizer.sv
// Streaming UDP packetizer: buffers an unstallable 64-bit word stream in a
// show-ahead FIFO and emits header + PAYLOAD_WORDS frames to the 10GbE core.
module gbe_tx_packetizer #(
  parameter int unsigned PAYLOAD_WORDS = 128,
  parameter int unsigned FIFO_DEPTH    = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [63:0] din,
  input  logic        din_valid,
  input  logic        din_sync,
  input  logic [15:0] hdr_id,
  input  logic [31:0] cfg_dest_ip,
  input  logic [15:0] cfg_dest_port,
  input  logic        stat_clr,
  output logic        tx_valid,
  output logic [63:0] tx_data,
  output logic        tx_end_of_frame,
  output logic [31:0] tx_dest_ip,
  output logic [15:0] tx_dest_port,
  input  logic        tx_afull,
  output logic        overflow,
  output logic        sync_err,
  output logic [47:0] pkt_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned FW = AW + 1;
  localparam int unsigned CW = $clog2(PAYLOAD_WORDS + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(FIFO_DEPTH);
  localparam logic [FW-1:0] FILL_PAY  = FW'(PAYLOAD_WORDS);
  localparam logic [CW-1:0] CNT_PAY   = CW'(PAYLOAD_WORDS);

  typedef enum logic {IDLE, PAY} state_e;

  // FIFO storage: {sync_tag, data}
  logic [64:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FW-1:0] fill_q, fill_d;
  logic          full, wr_en, pop;
  logic [64:0]   head;

  state_e        state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [47:0]   pkt_cnt_q, pkt_cnt_d, hdr_cnt;
  logic          tx_valid_q, tx_valid_d;
  logic [63:0]   tx_data_q, tx_data_d;
  logic          tx_eof_q, tx_eof_d;
  logic [31:0]   tx_ip_q, tx_ip_d;
  logic [15:0]   tx_port_q, tx_port_d;
  logic          overflow_q, overflow_d;
  logic          sync_err_q, sync_err_d;
  logic          sync_set;

  // Full is judged on the registered fill, so a same-cycle pop never frees room.
  assign full   = (fill_q == FILL_FULL);
  assign wr_en  = din_valid && !full;
  assign head   = mem[rd_ptr_q];
  assign fill_d = fill_q + FW'(wr_en) - FW'(pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= {din_sync, din};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      fill_q <= fill_d;
    end
  end

  assign hdr_cnt = head[64] ? '0 : pkt_cnt_q;

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    tx_valid_d = 1'b0;
    tx_eof_d   = 1'b0;
    tx_data_d  = tx_data_q;
    tx_ip_d    = tx_ip_q;
    tx_port_d  = tx_port_q;
    pop        = 1'b0;
    sync_set   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en && (fill_q >= FILL_PAY) && !tx_afull) begin
          tx_valid_d = 1'b1;
          tx_data_d  = {hdr_id, hdr_cnt};
          tx_ip_d    = cfg_dest_ip;
          tx_port_d  = cfg_dest_port;
          wcnt_d     = CNT_PAY;
          pkt_cnt_d  = hdr_cnt + 48'd1;
          state_d    = PAY;
        end
      end
      PAY: begin
        if (!tx_afull) begin
          pop        = 1'b1;
          tx_valid_d = 1'b1;
          tx_data_d  = head[63:0];
          wcnt_d     = wcnt_q - CW'(1);
          sync_set   = head[64] && (wcnt_q != CNT_PAY);
          if (wcnt_q == CW'(1)) begin
            tx_eof_d = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Flag set wins over a same-cycle clear.
  assign overflow_d = (din_valid && full) ? 1'b1 : (stat_clr ? 1'b0 : overflow_q);
  assign sync_err_d = sync_set ? 1'b1 : (stat_clr ? 1'b0 : sync_err_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wcnt_q     <= '0;
      pkt_cnt_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      tx_eof_q   <= 1'b0;
      tx_ip_q    <= '0;
      tx_port_q  <= '0;
      overflow_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      tx_eof_q   <= tx_eof_d;
      tx_ip_q    <= tx_ip_d;
      tx_port_q  <= tx_port_d;
      overflow_q <= overflow_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign tx_valid        = tx_valid_q;
  assign tx_data         = tx_data_q;
  assign tx_end_of_frame = tx_eof_q;
  assign tx_dest_ip      = tx_ip_q;
  assign tx_dest_port    = tx_port_q;
  assign overflow        = overflow_q;
  assign sync_err        = sync_err_q;
  assign pkt_cnt         = pkt_cnt_q;

endmodule

// File: tb/tb_gbe_tx_packetizer.sv
// Scoreboard bench for gbe_tx_packetizer with PAYLOAD_WORDS=4, FIFO_DEPTH=8.
module tb_gbe_tx_packetizer;

  localparam int unsigned PW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [63:0] din = '0;
  logic        din_valid = 1'b0;
  logic        din_sync = 1'b0;
  logic [15:0] hdr_id = 16'hBEEF;
  logic [31:0] cfg_dest_ip = 32'h0A000001;
  logic [15:0] cfg_dest_port = 16'd10000;
  logic        stat_clr = 1'b0;
  logic        tx_valid;
  logic [63:0] tx_data;
  logic        tx_end_of_frame;
  logic [31:0] tx_dest_ip;
  logic [15:0] tx_dest_port;
  logic        tx_afull = 1'b0;
  logic        overflow;
  logic        sync_err;
  logic [47:0] pkt_cnt;

  gbe_tx_packetizer #(.PAYLOAD_WORDS(4), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .din_valid(din_valid),
    .din_sync(din_sync), .hdr_id(hdr_id), .cfg_dest_ip(cfg_dest_ip),
    .cfg_dest_port(cfg_dest_port), .stat_clr(stat_clr), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_end_of_frame(tx_end_of_frame),
    .tx_dest_ip(tx_dest_ip), .tx_dest_port(tx_dest_port), .tx_afull(tx_afull),
    .overflow(overflow), .sync_err(sync_err), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Expected tx stream entries: {eof, data}
  logic [64:0] expq[$];
  logic [31:0] exp_ip   = 32'h0A000001;
  logic [15:0] exp_port = 16'd10000;
  logic [47:0] mpkt = '0;
  logic [63:0] grp_d[PW];
  logic        grp_s[PW];
  int unsigned grp_n = 0;

  task automatic model_accept(input logic [63:0] d, input logic s);
    logic [47:0] cnt;
    grp_d[grp_n] = d;
    grp_s[grp_n] = s;
    grp_n++;
    if (grp_n == PW) begin
      cnt = grp_s[0] ? 48'd0 : mpkt;
      expq.push_back({1'b0, 16'hBEEF, cnt});
      for (int i = 0; i < int'(PW); i++)
        expq.push_back({(i == int'(PW) - 1), grp_d[i]});
      mpkt  = cnt + 48'd1;
      grp_n = 0;
    end
  endtask

  task automatic put(input logic [63:0] d, input logic s, input logic drop);
    din = d; din_valid = 1'b1; din_sync = s;
    @(posedge clk); #1;
    din_valid = 1'b0; din_sync = 1'b0;
    if (!drop) model_accept(d, s);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (expq.size() == 0) break;
    end
    chk("drain", 64'(expq.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_word(input logic [63:0] d, output logic found);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #2;
      if (tx_valid && tx_data == d) begin found = 1'b1; break; end
    end
  endtask

  always @(negedge clk) begin
    logic [64:0] e;
    if (!rst && tx_valid) begin
      if (expq.size() == 0) chk("unexpected_word", {63'd0, tx_valid}, 64'd0);
      else begin
        e = expq.pop_front();
        chk("tx_data", tx_data, e[63:0]);
        chk("tx_eof", {63'd0, tx_end_of_frame}, {63'd0, e[64]});
        chk("tx_dest_ip", {32'd0, tx_dest_ip}, {32'd0, exp_ip});
        chk("tx_dest_port", {48'd0, tx_dest_port}, {48'd0, exp_port});
      end
    end
  end

  initial begin
    logic found;
    repeat (3) @(posedge clk); #1;
    chk("rst_valid", {63'd0, tx_valid}, 64'd0);
    chk("rst_eof", {63'd0, tx_end_of_frame}, 64'd0);
    chk("rst_data", tx_data, 64'd0);
    chk("rst_ip", {32'd0, tx_dest_ip}, 64'd0);
    chk("rst_port", {48'd0, tx_dest_port}, 64'd0);
    chk("rst_pkt", {16'd0, pkt_cnt}, 64'd0);
    chk("rst_flags", {62'd0, overflow, sync_err}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // basic frame; cfg changes mid-frame must not disturb dest fields
    en = 1'b1;
    put(64'h1, 1'b1, 1'b0);
    put(64'h2, 1'b0, 1'b0);
    put(64'h3, 1'b0, 1'b0);
    put(64'h4, 1'b0, 1'b0);
    wait_word(64'hBEEF000000000000, found);
    chk("basic_hdr_seen", {63'd0, found}, 64'd1);
    cfg_dest_ip = 32'hC0A80102; cfg_dest_port = 16'd4660;
    wait_drain();
    chk("basic_pkt_cnt", {16'd0, pkt_cnt}, {16'd0, mpkt});
    exp_ip = 32'hC0A80102; exp_port = 16'd4660;

    // backpressure after second payload word
    put(64'h10, 1'b0, 1'b0);
    put(64'h11, 1'b0, 1'b0);
    put(64'h12, 1'b0, 1'b0);
    put(64'h13, 1'b0, 1'b0);
    wait_word(64'h11, found);
    chk("bp_word2_seen", {63'd0, found}, 64'd1);
    tx_afull = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      chk("bp_gap", {63'd0, tx_valid}, 64'd0);
    end
    tx_afull = 1'b0;
    @(posedge clk); #2;
    chk("bp_resume_valid", {63'd0, tx_valid}, 64'd1);
    chk("bp_resume_data", tx_data, 64'h12);
    wait_drain();
    chk("bp_pkt_cnt", {16'd0, pkt_cnt}, {16'd0, mpkt});

    // counter: 12 words, sync on first; then sync on word 9
    for (int i = 0; i < 12; i++) put(64'h100 + 64'(i), (i == 0), 1'b0);
    wait_drain();
    chk("cnt_run1", {16'd0, pkt_cnt}, {16'd0, mpkt});
    for (int i = 0; i < 12; i++) put(64'h200 + 64'(i), (i == 8), 1'b0);
    wait_drain();
    chk("cnt_run2", {16'd0, pkt_cnt}, {16'd0, mpkt});

    // overflow: 10 words with launch blocked
    en = 1'b0;
    for (int i = 0; i < 10; i++) put(64'h300 + 64'(i), 1'b0, (i >= 8));
    repeat (2) @(posedge clk); #1;
    chk("ovf_set", {63'd0, overflow}, 64'd1);
    chk("ovf_no_tx", {63'd0, tx_valid}, 64'd0);
    en = 1'b1;
    wait_drain();
    chk("ovf_held", {63'd0, overflow}, 64'd1);
    chk("ovf_pkt_cnt", {16'd0, pkt_cnt}, {16'd0, mpkt});
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    chk("ovf_clr", {63'd0, overflow}, 64'd0);

    // misaligned sync on third payload word
    put(64'h400, 1'b0, 1'b0);
    put(64'h401, 1'b0, 1'b0);
    put(64'h402, 1'b1, 1'b0);
    put(64'h403, 1'b0, 1'b0);
    wait_drain();
    chk("sync_err_set", {63'd0, sync_err}, 64'd1);
    for (int i = 0; i < 4; i++) put(64'h500 + 64'(i), 1'b0, 1'b0);
    wait_drain();
    chk("sync_pkt_cnt", {16'd0, pkt_cnt}, {16'd0, mpkt});
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    chk("sync_err_clr", {63'd0, sync_err}, 64'd0);

    // reset mid-frame
    for (int i = 0; i < 4; i++) put(64'h600 + 64'(i), 1'b0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #2;
      if (tx_valid && tx_data[63:48] == 16'hBEEF) begin found = 1'b1; break; end
    end
    chk("rstmid_hdr_seen", {63'd0, found}, 64'd1);
    rst = 1'b1;
    #1;
    chk("rstmid_valid", {63'd0, tx_valid}, 64'd0);
    chk("rstmid_pkt", {16'd0, pkt_cnt}, 64'd0);
    expq.delete();
    mpkt = '0;
    grp_n = 0;
    exp_ip = '0; exp_port = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_ip = cfg_dest_ip; exp_port = cfg_dest_port;
    for (int i = 0; i < 3; i++) put(64'h700 + 64'(i), 1'b0, 1'b0);
    repeat (6) @(posedge clk); #1;
    chk("rstmid_quiet", {63'd0, tx_valid}, 64'd0);
    put(64'h703, 1'b0, 1'b0);
    wait_drain();
    chk("rstmid_pkt_after", {16'd0, pkt_cnt}, {16'd0, mpkt});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
